dcache_ctrl: RTL and testbench

//   Direct-mapped, write-back, write-allocate L1 data-cache controller between the MEM stage and
//   off-chip data memory. Owns the tag/valid/dirty/data arrays and sequences line write-back and

---
 rtl/dcache_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-back, write-allocate L1 data-cache controller.
//
// Sits between the MEM stage and off-chip data memory. It owns the tag, valid, dirty
// and data arrays. On a miss it writes back a dirty victim line, refills the line,
// and holds stall_o high until the request can retry as a hit.
//
// Ports
//   clk_i, rst_i            clock; synchronous active-high reset
//   req_i, write_i          MEM-stage access request; 1 = store, 0 = load
//   addr_i, wdata_i         byte address and store data
//                           (held stable by the frozen pipeline while stalled)
//   rdata_o                 load data, 0-cycle latency on a hit
//   stall_o                 pipeline freeze (combinational)
//   mem_enable_o            line transfer request, held until mem_ack_i
//   mem_write_o             1 = write-back, 0 = fetch
//   mem_addr_o              line-aligned transfer address
//   mem_data_o              victim line being written back
//   mem_data_i, mem_ack_i   refill line and one-cycle completion pulse
//   hit_cnt_o, miss_cnt_o   access statistics (only with DCACHE_STATS_EN)
//
// Optional feature macro: DCACHE_STATS_EN adds the hit/miss counters.
module dcache_ctrl #(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
`ifdef DCACHE_STATS_EN
   ,output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [LINE_W-1:0]  data_q [NUM_LINES];

    // Index/tag captured at miss detection; the refill lands here.
    logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
    logic [TAG_W-1:0]   lat_tag_q, lat_tag_d;

    logic               mem_en_d, mem_wr_d;
    logic [31:0]        mem_addr_d;
    logic [LINE_W-1:0]  mem_data_d;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic [LINE_W-1:0]  line_rd;
    logic               hit, miss, wr_hit, refill_we;
    logic               unused_addr;

    assign idx         = addr_i[5 +: IDX_W];
    assign tag         = addr_i[31 -: TAG_W];
    assign word        = addr_i[4:2];
    assign unused_addr = &{1'b0, addr_i[1:0]};

    assign hit       = req_i && valid_q[idx] && (tag_q[idx] == tag);
    assign miss      = req_i && !hit;
    assign stall_o   = (state_q == IDLE) ? miss : 1'b1;
    assign line_rd   = data_q[idx];
    assign rdata_o   = rst_i ? 32'h0 : line_rd[{word, 5'b0} +: 32];
    // Stores only commit in IDLE; in DONE the retry has not been re-evaluated yet.
    assign wr_hit    = (state_q == IDLE) && hit && write_i;
    assign refill_we = (state_q == REFILL) && mem_ack_i;

    always_comb begin
        state_d    = state_q;
        lat_idx_d  = lat_idx_q;
        lat_tag_d  = lat_tag_q;
        mem_en_d   = mem_enable_o;
        mem_wr_d   = mem_write_o;
        mem_addr_d = mem_addr_o;
        mem_data_d = mem_data_o;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    lat_idx_d = idx;
                    lat_tag_d = tag;
                    mem_en_d  = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d    = WRITEBACK;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = {tag_q[idx], idx, 5'b0};
                        mem_data_d = data_q[idx];
                    end else begin
                        state_d    = REFILL;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = {addr_i[31:5], 5'b0};
                    end
                end
            end
            WRITEBACK: begin
                // Enable stays high so the fetch goes out with no idle gap.
                if (mem_ack_i) begin
                    state_d    = REFILL;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {lat_tag_q, lat_idx_q, 5'b0};
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            lat_idx_q    <= '0;
            lat_tag_q    <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            lat_idx_q    <= lat_idx_d;
            lat_tag_q    <= lat_tag_d;
            mem_enable_o <= mem_en_d;
            mem_write_o  <= mem_wr_d;
            mem_addr_o   <= mem_addr_d;
            mem_data_o   <= mem_data_d;
            if (refill_we) begin
                valid_q[lat_idx_q] <= 1'b1;
                dirty_q[lat_idx_q] <= 1'b0;
            end else if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage is not reset; valid_q gates every use of it.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill_we) begin
                data_q[lat_idx_q] <= mem_data_i;
                tag_q[lat_idx_q]  <= lat_tag_q;
            end else if (wr_hit) begin
                data_q[idx][{word, 5'b0} +: 32] <= wdata_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // The first IDLE cycle after DONE is the retry of the miss just serviced.
    logic retry_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retry_q    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            retry_q <= (state_q == DONE);
            if ((state_q == IDLE) && hit && !retry_q) hit_cnt_o <= hit_cnt_o + 32'd1;
            if ((state_q == IDLE) && miss) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed table, hand sequences for multi-cycle corners,
// and randomized accesses against a flat-memory / line-residency reference model.
module tb_dcache_ctrl;
    localparam int NL = 16;

    logic         clk, rst_i, req_i, write_i;
    logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o;
    logic         stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [255:0] mem_data_o, mem_data_i;
    logic         resp_ack, man_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

    assign mem_ack_i = resp_ack | man_ack;

    dcache_ctrl #(.NUM_LINES(NL), .LINE_W(256)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_i(write_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
       ,.hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Backing memory (what off-chip memory holds) and architectural memory
    // (what a load must return). Unwritten words take init_word().
    logic [31:0] bmem    [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // Line residency model: which line address sits at each index and whether it is dirty.
    logic        res_valid [NL];
    logic [26:0] res_line  [NL];
    logic        res_dirty [NL];
    int          exp_hits, exp_misses;

    // Responder controls and transfer log.
    logic         auto_mem, fixed_lat;
    int           mem_lat;
    int           wb_cnt, rf_cnt;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a >> 2) - 32'h40;
    endfunction

    function automatic logic [31:0] bread(logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_line[i]  = '0;
        end
        ref_mem    = bmem;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                output logic m, output logic w, output logic [31:0] wa);
        int i;
        i  = int'((a >> 5) % NL);
        m  = !(res_valid[i] && res_line[i] == a[31:5]);
        w  = m && res_valid[i] && res_dirty[i];
        wa = {res_line[i], 5'b0};
        if (m) begin
            res_valid[i] = 1'b1;
            res_line[i]  = a[31:5];
            res_dirty[i] = 1'b0;
            exp_misses++;
        end else begin
            exp_hits++;
        end
        if (wr) begin
            res_dirty[i] = 1'b1;
            ref_mem[{a[31:2], 2'b00}] = wd;
        end
    endtask

    // Called at a negedge; returns at a negedge with req_i dropped.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output int cyc);
        req_i = 1'b1; write_i = wr; addr_i = a; wdata_i = wd;
        cyc = 0;
        #1;
        while (stall_o && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        if (cyc >= 200) begin
            checks++; failures++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", a, cyc);
        end
        rd = rdata_o;
        @(negedge clk);
        req_i = 1'b0; write_i = 1'b0;
    endtask

    task automatic access_chk(input string nm, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int exp_cyc);
        logic [31:0] exp_rd, rd, wa;
        logic m, w;
        int cyc, wb0, rf0;
        exp_rd = ref_read({a[31:2], 2'b00});
        wb0 = wb_cnt; rf0 = rf_cnt;
        model_access(wr, a, wd, m, w, wa);
        do_access(wr, a, wd, rd, cyc);
        if (!wr) chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_miss"}, cyc != 0, m);
        chk({nm, "_wb_count"}, wb_cnt - wb0, w ? 1 : 0);
        chk({nm, "_refill_count"}, rf_cnt - rf0, m ? 1 : 0);
        if (w) chk({nm, "_wb_addr"}, last_wb_addr, wa);
        if (exp_cyc >= 0) chk({nm, "_cycles"}, cyc, exp_cyc);
    endtask

    // Memory responder: serves mem_enable_o requests after mem_lat (or random) cycles.
    initial begin
        logic         w;
        logic [31:0]  a;
        logic [255:0] d, exp_line;
        int           lat;
        resp_ack   = 1'b0;
        mem_data_i = '0;
        @(negedge clk);
        forever begin
            if (auto_mem && mem_enable_o && !rst_i) begin
                w = mem_write_o; a = mem_addr_o; d = mem_data_o;
                lat = fixed_lat ? mem_lat : int'($urandom_range(1, 4));
                repeat (lat - 1) @(negedge clk);
                if (w) begin
                    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = ref_read(a + 32'(4*k));
                    chk("wb_line_data", d, exp_line);
                    for (int k = 0; k < 8; k++) bmem[a + 32'(4*k)] = d[k*32 +: 32];
                    wb_cnt++; last_wb_addr = a; last_wb_data = d;
                end else begin
                    for (int k = 0; k < 8; k++) mem_data_i[k*32 +: 32] = bread(a + 32'(4*k));
                    rf_cnt++;
                end
                resp_ack = 1'b1;
                @(negedge clk);
                resp_ack = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_miss;
        logic        exp_wb;
        logic [31:0] exp_wb_addr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] rd, wa;
        logic m, w;
        int cyc, wb0, rf0;

        // Starts right after the test-1 load leaves line 0x100 resident and clean.
        tbl[0] = '{1'b1, 32'h104, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h300, 32'h0,        32'h80,       1'b1, 1'b1, 32'h100};
        tbl[3] = '{1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 32'h11C, 32'h12345678, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[5] = '{1'b0, 32'h11C, 32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 32'h100, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0};
        tbl[7] = '{1'b1, 32'h520, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 32'h520, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        tbl[9] = '{1'b0, 32'h720, 32'h0,        32'h188,      1'b1, 1'b1, 32'h520};

        rst_i = 1'b1; req_i = 1'b0; write_i = 1'b0; addr_i = '0; wdata_i = '0;
        man_ack = 1'b0; auto_mem = 1'b1; fixed_lat = 1'b1; mem_lat = 4;
        wb_cnt = 0; rf_cnt = 0; last_wb_addr = '0; last_wb_data = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_enable", mem_enable_o, 0);
        chk("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_rdata", rdata_o, 0);
        @(negedge clk);
        rst_i = 1'b0;
        #1 chk("idle_stall", stall_o, 0);
        @(negedge clk);

        // Test 1: cold load 0x100, 4-cycle memory
        req_i = 1'b1; write_i = 1'b0; addr_i = 32'h100;
        #1 chk("t1_stall_on_miss", stall_o, 1);
        @(negedge clk); #1;
        chk("t1_mem_enable", mem_enable_o, 1);
        chk("t1_mem_write", mem_write_o, 0);
        chk("t1_mem_addr", mem_addr_o, 32'h100);
        cyc = 1;
        while (stall_o && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        chk("t1_miss_penalty", cyc, 6);
        chk("t1_rdata_word0", rdata_o, 32'h0);
        @(negedge clk);
        req_i = 1'b0;
        model_access(1'b0, 32'h100, 32'h0, m, w, wa);

`ifdef DCACHE_STATS_EN
        access_chk("t6_hit_a", 1'b0, 32'h104, 32'h0, 0);
        access_chk("t6_hit_b", 1'b0, 32'h108, 32'h0, 0);
        access_chk("t6_hit_c", 1'b0, 32'h10C, 32'h0, 0);
        #1;
        chk("t6_miss_cnt", miss_cnt_o, 1);
        chk("t6_hit_cnt", hit_cnt_o, 3);
`endif

        // Tests 2/3 and more: directed table, 3-cycle memory
        mem_lat = 3;
        for (int i = 0; i < 10; i++) begin
            wb0 = wb_cnt; rf0 = rf_cnt;
            model_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, m, w, wa);
            do_access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, cyc);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_miss", i), cyc != 0, tbl[i].exp_miss);
            chk($sformatf("tbl%0d_cycles", i), cyc,
                tbl[i].exp_miss ? (tbl[i].exp_wb ? 8 : 5) : 0);
            chk($sformatf("tbl%0d_wb_count", i), wb_cnt - wb0, tbl[i].exp_wb ? 1 : 0);
            if (tbl[i].exp_wb) chk($sformatf("tbl%0d_wb_addr", i), last_wb_addr, tbl[i].exp_wb_addr);
            if (i == 2) chk("tbl2_wb_word1", last_wb_data[63:32], 32'hDEADBEEF);
        end

        // Test 5: ack pulse while idle with no request
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        chk("t5_stall", stall_o, 0);
        chk("t5_mem_enable", mem_enable_o, 0);
        @(negedge clk);
        access_chk("t5_hit_after", 1'b0, 32'h100, 32'h0, 0);

        // Test 4: reset during REFILL, then a stray ack
        auto_mem = 1'b0;
        req_i = 1'b1; write_i = 1'b0; addr_i = 32'h2000;
        @(negedge clk); #1;
        chk("t4_refill_enable", mem_enable_o, 1);
        chk("t4_refill_write", mem_write_o, 0);
        rst_i = 1'b1; req_i = 1'b0;
        #1 chk("t4_rdata_in_reset", rdata_o, 0);
        @(negedge clk);
        rst_i = 1'b0; man_ack = 1'b1;
        #1 chk("t4_enable_after_rst", mem_enable_o, 0);
        @(negedge clk);
        man_ack = 1'b0;
        #1;
        chk("t4_enable_after_ack", mem_enable_o, 0);
        chk("t4_stall_after_ack", stall_o, 0);
        model_reset();
        auto_mem = 1'b1;
        @(negedge clk);
        access_chk("t4_reload", 1'b0, 32'h100, 32'h0, 5);

        // Flush: request drops mid-miss, the fill still completes
        req_i = 1'b1; write_i = 1'b0; addr_i = 32'h8000;
        @(negedge clk);
        req_i = 1'b0;
        cyc = 0;
        while (mem_enable_o && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("flush_enable_done", mem_enable_o, 0);
        chk("flush_stall", stall_o, 0);
        model_access(1'b0, 32'h8000, 32'h0, m, w, wa);
        @(negedge clk);
        access_chk("flush_then_hit", 1'b0, 32'h8000, 32'h0, 0);

        // Randomized accesses over 4 tags x all indices, random memory latency
        fixed_lat = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            a = 32'h4000 | (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, NL-1)) << 5)
                | (32'($urandom_range(0, 7)) << 2);
            access_chk("rnd", 1'($urandom_range(0, 1)), a, $urandom, -1);
        end

`ifdef DCACHE_STATS_EN
        #1;
        chk("end_miss_cnt", miss_cnt_o, exp_misses);
        chk("end_hit_cnt", hit_cnt_o, exp_hits);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
